uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits on the CPU data bus under `top`. It is the responder for the core's load/store initiator, and it is the console output the simulation bench observes. It accepts byte writes into a small FIFO and serialises them 8N1, LSB first, on `tx`. It also exposes a status register that firmware polls before writing.

---
 rtl/uart_tx_mmio.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
module uart_tx_mmio #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic        tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLK_DIV);

  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [3:0]    ADDR_TXDATA = 4'h0;
  localparam logic [3:0]    ADDR_STATUS = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic          bus_ready_q;
  logic [31:0]   bus_rdata_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          baud_last;
  logic          is_txdata;
  logic          is_status;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   status_word;
  logic [31:0]   read_word;
  logic          unused_wdata;

  assign fifo_full  = (count_q == COUNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign baud_last  = (baud_q == BAUD_LAST);
  assign is_txdata  = (bus_addr == ADDR_TXDATA);
  assign is_status  = (bus_addr == ADDR_STATUS);

  // The ready pulse itself blocks acceptance, so a master still holding
  // valid during its completion cycle cannot cause a second push.
  assign accept = bus_valid && !bus_ready_q && !(bus_we && is_txdata && fifo_full);
  assign push   = accept && bus_we && is_txdata;

  // Pop from IDLE, or at the last stop-bit cycle to chain frames with no gap.
  assign pop = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));

  assign unused_wdata = ^bus_wdata[31:8];

  // Status snapshot built from registered state, so a same-edge pop is not visible.
  always_comb begin
    status_word       = '0;
    status_word[0]    = fifo_full;
    status_word[1]    = fifo_empty;
    status_word[2]    = (state_q != S_IDLE);
    status_word[11:8] = 4'(count_q);
  end

  // Only STATUS returns data; TXDATA and unmapped reads return zero.
  always_comb begin
    read_word = '0;
    if (is_status) begin
      read_word = status_word;
    end
  end

  // FIFO storage; contents need no reset because pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr_q] <= bus_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmit FSM with registered line output; every bit lasts CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= fifo_mem[rd_ptr_q];
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= fifo_mem[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Bus completion: one-cycle ready pulse, read data present only with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ready_q <= 1'b0;
      bus_rdata_q <= '0;
    end else begin
      bus_ready_q <= accept;
      bus_rdata_q <= (accept && !bus_we) ? read_word : '0;
    end
  end

  assign bus_ready = bus_ready_q;
  assign bus_rdata = bus_rdata_q;
  assign tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio with line decoder and byte model
module tb_uart_tx_mmio;

  localparam int CD    = 4;
  localparam int FD    = 8;
  localparam int FRAME = 10 * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        tx;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         mon_bad = 0;
  int         mon_cur_start = -1;

  uart_tx_mmio #(.CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: finds a start bit, collects 10 bit times, flags any bit that is not steady.
  initial begin
    int         st;
    logic [9:0] bits;
    logic       clean;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        st            = cyc;
        mon_cur_start = st;
        bits          = '0;
        clean         = 1'b1;
        aborted       = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (i % CD == 0) bits[i / CD] = tx;
          else if (tx !== bits[i / CD]) clean = 1'b0;
        end
        if (!aborted) begin
          if (bits[9] !== 1'b1) clean = 1'b0;
          if (!clean) mon_bad++;
          rx_q.push_back(bits[8:1]);
          rx_start.push_back(st);
        end
      end
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return ((b >> (k - 1)) & 8'h01) != 0;
  endfunction

  task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat, output int ready_cyc);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    lat       = -1;
    rdata     = '0;
    ready_cyc = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (bus_ready === 1'b1) begin
        lat       = i;
        rdata     = bus_rdata;
        ready_cyc = cyc;
        break;
      end
    end
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    @(negedge clk);
  endtask

  task automatic wait_drain(output bit ok);
    logic [31:0] rd;
    int lat, rc;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
      if (lat > 0 && rd == 32'h2) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat, rc;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_total++;
    if (bus_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus_ready); else n_pass++;
    n_total++;
    if (bus_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus_rdata); else n_pass++;
    rst = 1'b0;
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
    n_total++;
    if (lat !== 1) $display("FAIL reset_status_lat: got %0d want 1", lat); else n_pass++;
    n_total++;
    if (rd !== 32'h2) $display("FAIL reset_status: got %h want 00000002", rd); else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] rd;
    int lat, rc, errs;
    bit ok;
    logic [7:0] b;
    b = 8'hA5;
    rx_q.delete();
    rx_start.delete();
    bus_xfer(1'b1, 4'h0, {24'h0, b}, rd, lat, rc);
    n_total++;
    if (lat !== 1) $display("FAIL single_lat: got %0d want 1", lat); else n_pass++;
    n_total++;
    if (tx !== 1'b1) $display("FAIL single_tx_before_pop: got %b want 1", tx); else n_pass++;
    errs = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_total++;
        if (bus_ready !== 1'b0) $display("FAIL single_ready_pulse: got %b want 0", bus_ready); else n_pass++;
      end
      if (tx !== frame_bit(b, k / CD)) errs++;
    end
    n_total++;
    if (errs != 0) $display("FAIL single_waveform: got %0d bad cycles want 0", errs); else n_pass++;
    @(negedge clk);
    n_total++;
    if (tx !== 1'b1) $display("FAIL single_tx_after: got %b want 1", tx); else n_pass++;
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
    n_total++;
    if (rd !== 32'h2) $display("FAIL single_status_after: got %h want 00000002", rd); else n_pass++;
    wait_drain(ok);
    n_total++;
    if (rx_q.size() != 1 || rx_q[0] !== b)
      $display("FAIL single_rx: got %0d bytes first %h want 1 byte %h", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'h00, b);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int lat, rc;
    bit ok;
    rx_q.delete();
    rx_start.delete();
    bus_xfer(1'b1, 4'h0, 32'h55, rd, lat, rc);
    bus_xfer(1'b1, 4'h0, 32'h0F, rd, lat, rc);
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
    n_total++;
    if (rd !== 32'h104) $display("FAIL b2b_status: got %h want 00000104", rd); else n_pass++;
    wait_drain(ok);
    n_total++;
    if (!ok) $display("FAIL b2b_drain: got timeout want idle"); else n_pass++;
    n_total++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'h0F)
      $display("FAIL b2b_rx: got %0d bytes want 55 0f", rx_q.size());
    else n_pass++;
    n_total++;
    if (rx_start.size() != 2 || rx_start[1] - rx_start[0] != FRAME)
      $display("FAIL b2b_gap: got %0d starts want spacing %0d", rx_start.size(), FRAME);
    else n_pass++;
    n_total++;
    if (mon_bad != 0) $display("FAIL b2b_framing: got %0d bad frames want 0", mon_bad); else n_pass++;
  endtask

  task automatic test_full_stall();
    logic [31:0] rd;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    int lat, rc, lat_errs, gap_errs;
    bit ok;
    rx_q.delete();
    rx_start.delete();
    lat_errs = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      bus_xfer(1'b1, 4'h0, {24'h0, b}, rd, lat, rc);
      if (lat != 1) lat_errs++;
    end
    n_total++;
    if (lat_errs != 0) $display("FAIL stall_fill_lat: got %0d slow writes want 0", lat_errs); else n_pass++;
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
    n_total++;
    if (rd !== 32'h805) $display("FAIL stall_status_full: got %h want 00000805", rd); else n_pass++;
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    bus_xfer(1'b1, 4'h0, {24'h0, b}, rd, lat, rc);
    n_total++;
    if (lat <= 1) $display("FAIL stall_held: got latency %0d want >1", lat); else n_pass++;
    n_total++;
    if (rc != mon_cur_start + 1)
      $display("FAIL stall_accept_edge: got cycle %0d want %0d", rc, mon_cur_start + 1);
    else n_pass++;
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
    n_total++;
    if (rd !== 32'h805) $display("FAIL stall_status_refill: got %h want 00000805", rd); else n_pass++;
    wait_drain(ok);
    n_total++;
    if (!ok) $display("FAIL stall_drain: got timeout want idle"); else n_pass++;
    n_total++;
    if (rx_q != exp_q) $display("FAIL stall_order: got %0d bytes want %0d in order", rx_q.size(), exp_q.size());
    else n_pass++;
    gap_errs = 0;
    for (int i = 1; i < rx_start.size(); i++)
      if (rx_start[i] - rx_start[i-1] != FRAME) gap_errs++;
    n_total++;
    if (gap_errs != 0 || mon_bad != 0)
      $display("FAIL stall_framing: got %0d gaps %0d bad frames want 0 0", gap_errs, mon_bad);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    int lat, rc;
    rx_q.delete();
    rx_start.delete();
    bus_xfer(1'b1, 4'h8, 32'hFF, rd, lat, rc);
    n_total++;
    if (lat !== 1) $display("FAIL unmapped_wr_lat: got %0d want 1", lat); else n_pass++;
    bus_xfer(1'b1, 4'h4, 32'hFF, rd, lat, rc);
    n_total++;
    if (lat !== 1) $display("FAIL status_wr_lat: got %0d want 1", lat); else n_pass++;
    bus_xfer(1'b0, 4'hC, 32'h0, rd, lat, rc);
    n_total++;
    if (lat !== 1 || rd !== 32'h0) $display("FAIL unmapped_rd: got %h lat %0d want 0 lat 1", rd, lat); else n_pass++;
    bus_xfer(1'b0, 4'h0, 32'h0, rd, lat, rc);
    n_total++;
    if (rd !== 32'h0) $display("FAIL txdata_rd: got %h want 0", rd); else n_pass++;
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
    n_total++;
    if (rd !== 32'h2) $display("FAIL unmapped_status: got %h want 00000002", rd); else n_pass++;
    repeat (2 * FRAME) @(negedge clk);
    n_total++;
    if (rx_q.size() != 0) $display("FAIL unmapped_no_frame: got %0d frames want 0", rx_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic [3:0]  a;
    logic [3:0]  cnt;
    int lat, rc, op;
    bit ok;
    rx_q.delete();
    rx_start.delete();
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        bus_xfer(1'b1, 4'h0, {$urandom, b} >> 0, rd, lat, rc);
        n_total++;
        if (lat < 1) $display("FAIL rand_push_%0d: got timeout want ready", i); else n_pass++;
      end else if (op == 5 || op == 6) begin
        if (op == 5) a = 4'h4;
        else begin
          do a = 4'($urandom_range(0, 15)); while (a == 4'h0 || a == 4'h4);
        end
        bus_xfer(1'b1, a, $urandom, rd, lat, rc);
        n_total++;
        if (lat !== 1) $display("FAIL rand_ignored_wr_%0d: got lat %0d want 1", i, lat); else n_pass++;
      end else if (op == 7 || op == 8) begin
        if (op == 7) a = 4'h0;
        else begin
          do a = 4'($urandom_range(0, 15)); while (a == 4'h0 || a == 4'h4);
        end
        bus_xfer(1'b0, a, 32'h0, rd, lat, rc);
        n_total++;
        if (rd !== 32'h0) $display("FAIL rand_zero_rd_%0d: got %h want 0", i, rd); else n_pass++;
      end else begin
        bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
        cnt = rd[11:8];
        n_total++;
        if ((rd & 32'hFFFF_F0F8) != 0 || cnt > FD || rd[0] != (cnt == FD) || rd[1] != (cnt == 0))
          $display("FAIL rand_status_%0d: got %h want consistent full/empty/count", i, rd);
        else n_pass++;
      end
    end
    wait_drain(ok);
    n_total++;
    if (!ok) $display("FAIL rand_drain: got timeout want idle"); else n_pass++;
    n_total++;
    if (rx_q != exp_q) $display("FAIL rand_stream: got %0d bytes want %0d matching", rx_q.size(), exp_q.size());
    else n_pass++;
    n_total++;
    if (mon_bad != 0) $display("FAIL rand_framing: got %0d bad frames want 0", mon_bad); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    logic [7:0]  b;
    int lat, rc, guard;
    rx_q.delete();
    rx_start.delete();
    b = 8'($urandom_range(0, 255)) & 8'hF7;
    bus_xfer(1'b1, 4'h0, {24'h0, b}, rd, lat, rc);
    for (int i = 0; i < 3; i++) bus_xfer(1'b1, 4'h0, $urandom, rd, lat, rc);
    guard = 0;
    while (cyc < mon_cur_start + 17 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_total++;
    if (tx !== 1'b0) $display("FAIL midframe_bit3: got %b want 0", tx); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (tx !== 1'b1) $display("FAIL midframe_abort_tx: got %b want 1", tx); else n_pass++;
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 4'h0;
    bus_wdata = 32'h3C;
    @(posedge clk);
    #1;
    n_total++;
    if (bus_ready !== 1'b0) $display("FAIL reset_drops_req: got %b want 0", bus_ready); else n_pass++;
    @(negedge clk);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    rst       = 1'b0;
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat, rc);
    n_total++;
    if (rd !== 32'h2) $display("FAIL midframe_status: got %h want 00000002", rd); else n_pass++;
    repeat (3 * FRAME) @(negedge clk);
    n_total++;
    if (rx_q.size() != 0) $display("FAIL midframe_no_frames: got %0d frames want 0", rx_q.size()); else n_pass++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_unmapped();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
